// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: byte strobe in, key event FIFO out, sticky status flags.
interface ps2_scancode_decoder_if;
    logic [7:0] code_in;
    logic       code_valid;
    logic [9:0] evt_data;
    logic       evt_valid;
    logic       evt_rd;
    logic       overflow;
    logic       code_err;
    logic       flag_clr;
    modport master (output code_in, code_valid, evt_rd, flag_clr,
                    input  evt_data, evt_valid, overflow, code_err);
    modport slave  (input  code_in, code_valid, evt_rd, flag_clr,
                    output evt_data, evt_valid, overflow, code_err);
endinterface

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: Set 2 scan code sequences to {release, extended, code} events
// buffered in a first-word-fall-through FIFO.
module ps2_scancode_decoder #(
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 32000
) (
    input logic                  clk,
    input logic                  rst,
    ps2_scancode_decoder_if.slave bus
);
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, PAUSE} state_t;
    state_t             state, state_n, eff;
    logic [2:0]         skip, skip_n;
    logic [GW-1:0]      gap;
    logic [7:0]         b;
    logic               timeout, pfx, status, bad, fresh;
    logic               push, err_set;
    logic [9:0]         push_data;
    logic [9:0]         mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, empty, pop, wr, ovf_set;
    assign b       = bus.code_in;
    assign timeout = state != IDLE && gap == GW'(TIMEOUT_CYCLES);
    assign eff     = timeout ? IDLE : state;
    assign pfx     = b == 8'hE0 || b == 8'hF0 || b == 8'hE1;
    assign status  = b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE;
    assign bad     = b == 8'h00 || b == 8'hFF;
    // A stray prefix mid-sequence abandons it and starts over as if in IDLE.
    assign fresh   = eff == IDLE || (pfx && eff != PAUSE && !(eff == EXT && b == 8'hF0));
    always_comb begin
        state_n   = state;
        skip_n    = skip;
        push      = 1'b0;
        push_data = {2'b00, b};
        err_set   = 1'b0;
        if (bus.code_valid) begin
            if (fresh) begin
                state_n = b == 8'hE0 ? EXT : b == 8'hF0 ? BRK : b == 8'hE1 ? PAUSE : IDLE;
                skip_n  = b == 8'hE1 ? 3'd7 : skip;
                err_set = bad;
                push    = !pfx && !status && !bad;
            end else if (eff == PAUSE) begin
                skip_n    = skip - 3'd1;
                push      = skip == 3'd1;
                push_data = {2'b01, 8'hE1};
                state_n   = skip == 3'd1 ? IDLE : PAUSE;
            end else if (eff == EXT && b == 8'hF0) begin
                state_n = EXTBRK;
            end else begin
                state_n   = IDLE;
                push      = !(b == 8'h12 && eff != BRK);
                push_data = {eff != EXT, eff != BRK, b};
            end
        end else if (timeout) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            skip  <= '0;
            gap   <= '0;
        end else begin
            state <= state_n;
            skip  <= skip_n;
            gap   <= (bus.code_valid || eff == IDLE) ? '0 : gap + GW'(1);
        end
    end
    assign full    = count[FIFO_AW];
    assign empty   = count == '0;
    assign pop     = bus.evt_rd && !empty;
    assign wr      = push && (!full || pop);
    assign ovf_set = push && full && !pop;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem          <= '{default: '0};
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            bus.overflow <= 1'b0;
            bus.code_err <= 1'b0;
        end else begin
            if (wr) mem[wr_ptr] <= push_data;
            wr_ptr       <= wr_ptr + FIFO_AW'(wr);
            rd_ptr       <= rd_ptr + FIFO_AW'(pop);
            count        <= count + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(pop);
            bus.overflow <= ovf_set || (bus.overflow && !bus.flag_clr);
            bus.code_err <= err_set || (bus.code_err && !bus.flag_clr);
        end
    end
    assign bus.evt_valid = !empty;
    assign bus.evt_data  = mem[rd_ptr];
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed scan code sequences with hand-computed events.
module tb_ps2_scancode_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    ps2_scancode_decoder_if ifc();
    ps2_scancode_decoder #(.FIFO_AW(3), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic put(input logic [7:0] c);
        ifc.code_in    = c;
        ifc.code_valid = 1'b1;
        @(negedge clk);
        ifc.code_valid = 1'b0;
    endtask
    task automatic pop_chk(input string tag, input logic [9:0] exp);
        chk(tag, {ifc.evt_valid, ifc.evt_data}, {1'b1, exp});
        ifc.evt_rd = 1'b1;
        @(negedge clk);
        ifc.evt_rd = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    logic [7:0] fill [9] = '{8'h15, 8'h16, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h21, 8'h22};
    initial begin
        ifc.code_in = '0; ifc.code_valid = 1'b0; ifc.evt_rd = 1'b0; ifc.flag_clr = 1'b0;
        idle(3);
        chk("rst_valid", ifc.evt_valid, 0);
        chk("rst_data", ifc.evt_data, 0);
        chk("rst_ovf", ifc.overflow, 0);
        chk("rst_err", ifc.code_err, 0);
        rst = 1'b0;
        idle(2);
        put(8'h1C);
        chk("latency", {ifc.evt_valid, ifc.evt_data}, 11'h41C);
        put(8'hF0); put(8'h1C);
        pop_chk("make", 10'h01C);
        pop_chk("break", 10'h21C);
        chk("empty1", ifc.evt_valid, 0);
        put(8'hE0); put(8'h75); put(8'hE0); put(8'hF0); put(8'h75); put(8'hE0); put(8'h12);
        idle(1);
        pop_chk("ext_make", 10'h175);
        pop_chk("ext_break", 10'h375);
        chk("fake_shift", ifc.evt_valid, 0);
        put(8'hE1); put(8'h14); put(8'h77); put(8'hE1); put(8'hF0); put(8'h14); put(8'hF0);
        chk("pause_7", ifc.evt_valid, 0);
        put(8'h77);
        pop_chk("pause", 10'h1E1);
        chk("pause_once", ifc.evt_valid, 0);
        put(8'hAA); put(8'hFA);
        idle(1);
        chk("status_drop", ifc.evt_valid, 0);
        chk("err_before", ifc.code_err, 0);
        put(8'hFF);
        chk("err_set", ifc.code_err, 1);
        idle(3);
        chk("err_sticky", ifc.code_err, 1);
        chk("err_noevt", ifc.evt_valid, 0);
        ifc.flag_clr = 1'b1; idle(1); ifc.flag_clr = 1'b0;
        chk("err_clr", ifc.code_err, 0);
        put(8'hE0); idle(50); put(8'h1C);
        pop_chk("in_window", 10'h11C);
        put(8'hE0); idle(110); put(8'h1C);
        pop_chk("timeout", 10'h01C);
        chk("timeout_empty", ifc.evt_valid, 0);
        for (int i = 0; i < 9; i++) put(fill[i]);
        chk("ovf_set", ifc.overflow, 1);
        for (int i = 0; i < 8; i++) pop_chk($sformatf("fifo_%0d", i), {2'b00, fill[i]});
        chk("fifo_drained", ifc.evt_valid, 0);
        ifc.flag_clr = 1'b1; idle(1); ifc.flag_clr = 1'b0;
        chk("ovf_clr", ifc.overflow, 0);
        for (int i = 0; i < 8; i++) put(8'h30 + 8'(i));
        ifc.evt_rd = 1'b1;
        put(8'h3A);
        ifc.evt_rd = 1'b0;
        chk("pushpop_no_ovf", ifc.overflow, 0);
        for (int i = 1; i < 8; i++) pop_chk($sformatf("pp_%0d", i), 10'h030 + 10'(i));
        pop_chk("pp_new", 10'h03A);
        chk("pp_count8", ifc.evt_valid, 0);
        put(8'h1C); put(8'h1B); put(8'h23); put(8'hF0);
        chk("pre_rst_valid", ifc.evt_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", ifc.evt_valid, 0);
        chk("rst_async_data", ifc.evt_data, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        put(8'h1C);
        pop_chk("post_rst", 10'h01C);
        chk("post_rst_empty", ifc.evt_valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
